// File: rtl/scroll_pkg.sv
// Shared encodings for the scrolling frame-address generator.
// Directions and controller states used by top and offset control.
package scroll_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_PAUSED    = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/scroll_offset_ctrl.sv
// Run/pause/step controller and wrapping scroll offsets.
// Offsets only move in a frame_tick cycle, so there is no tearing.
module scroll_offset_ctrl
  import scroll_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int STEP  = 1,
  parameter int SPD_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             btn_pulse,
  input  logic             step_pulse,
  input  logic [1:0]       dir,
  input  logic [SPD_W-1:0] speed,
  output logic             running,
  output logic [8:0]       x_off,
  output logic [8:0]       y_off
);

  localparam logic [9:0] W_L = 10'(IMG_W);
  localparam logic [9:0] H_L = 10'(IMG_H);
  localparam logic [9:0] S_L = 10'(STEP);

  state_e           state_q, state_d;
  logic [SPD_W-1:0] cnt_q, cnt_d;
  logic [8:0]       x_q, x_d, y_q, y_d;
  logic             do_step;
  logic [9:0]       x_ext, y_ext, x_sum, y_sum;

  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};
  assign x_sum = x_ext + S_L;
  assign y_sum = y_ext + S_L;

  // Next state, frame counter and step decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    do_step = 1'b0;
    unique case (state_q)
      ST_PAUSED: begin
        if (btn_pulse) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (step_pulse) begin
          state_d = ST_STEP_PEND;
        end
      end
      ST_STEP_PEND: begin
        if (btn_pulse) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else if (frame_tick) begin
          do_step = 1'b1;
          state_d = ST_PAUSED;
        end
      end
      ST_RUN: begin
        if (frame_tick) begin
          if (cnt_q >= speed) begin
            do_step = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (btn_pulse) state_d = ST_PAUSED;
      end
      default: state_d = ST_PAUSED;
    endcase
  end

  // Wrapped offsets for one step in the sampled direction.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (do_step) begin
      unique case (dir)
        DIR_UP:
          y_d = (y_sum >= H_L) ? 9'(y_sum - H_L) : 9'(y_sum);
        DIR_DOWN:
          y_d = (y_ext < S_L) ? 9'(y_ext + H_L - S_L)
                              : 9'(y_ext - S_L);
        DIR_LEFT:
          x_d = (x_sum >= W_L) ? 9'(x_sum - W_L) : 9'(x_sum);
        DIR_RIGHT:
          x_d = (x_ext < S_L) ? 9'(x_ext + W_L - S_L)
                              : 9'(x_ext - S_L);
        default: ;
      endcase
    end
  end

  // State, counter and offset registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PAUSED;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign x_off   = x_q;
  assign y_off   = y_q;

endmodule

// File: rtl/scroll_addr_gen.sv
// Maps VGA counters to a scrolled, wrapped frame-buffer address.
// Address is registered with exactly one clock of latency.
module scroll_addr_gen
  import scroll_pkg::*;
#(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 17,
  parameter int STEP        = 1,
  parameter int SPD_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              valid,
  input  logic              frame_tick,
  input  logic              btn_pulse,
  input  logic              step_pulse,
  input  logic [1:0]        dir,
  input  logic [SPD_W-1:0]  speed,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              running,
  output logic [8:0]        x_off,
  output logic [8:0]        y_off
);

  localparam logic [10:0] W_L = 11'(IMG_W);
  localparam logic [10:0] H_L = 11'(IMG_H);

  logic [9:0]        xs, ys;
  logic [10:0]       xsum, ysum, xi, yi;
  logic              in_img;
  logic [ADDR_W-1:0] addr_d, addr_q;

  scroll_offset_ctrl #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .STEP  (STEP),
    .SPD_W (SPD_W)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .btn_pulse  (btn_pulse),
    .step_pulse (step_pulse),
    .dir        (dir),
    .speed      (speed),
    .running    (running),
    .x_off      (x_off),
    .y_off      (y_off)
  );

  assign xs   = h_cnt >> SCALE_SHIFT;
  assign ys   = v_cnt >> SCALE_SHIFT;
  assign xsum = {1'b0, xs} + {2'b0, x_off};
  assign ysum = {1'b0, ys} + {2'b0, y_off};
  assign xi   = (xsum >= W_L) ? xsum - W_L : xsum;
  assign yi   = (ysum >= H_L) ? ysum - H_L : ysum;
  assign in_img = valid && ({1'b0, xs} < W_L)
                        && ({1'b0, ys} < H_L);

  // Row-major address; blanking and off-image pixels read address 0.
  always_comb begin
    addr_d = '0;
    if (in_img)
      addr_d = ADDR_W'(yi) * ADDR_W'(IMG_W) + ADDR_W'(xi);
  end

  // Output address register.
  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign pixel_addr = addr_q;

endmodule
